// File: rtl/pid_pwm_pkg.sv
// Purpose : shared types and helpers for the PID PWM output stage (channel FSM states,
//           period limit, saturating magnitude).
// Latency : n/a (package). Backpressure: n/a.
package pid_pwm_pkg;

  // Per-channel drive state. DEAD only exists when PID_PWM_DEADTIME_EN is defined.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } pwm_state_t;

  // Last value of the shared period counter for a signed power word of width w.
  // Period is MAXC+1 = 2^(w-1)-1 clocks, so a magnitude of MAXC+1 means 100% drive.
  function automatic int pwm_maxc(input int w);
    return (1 << (w - 1)) - 2;
  endfunction

  // Absolute value of a w-bit signed word (sign-extended into v). The most negative
  // value has no positive counterpart in w-1 bits, so it folds onto full scale.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int w);
    logic signed [31:0] lo;
    lo = -(32'sd1 <<< (w - 1));
    if (v == lo) begin
      return 32'((1 << (w - 1)) - 1);
    end else if (v < 0) begin
      return 32'(-v);
    end else begin
      return 32'(v);
    end
  endfunction

endpackage

// File: rtl/pid_pwm_chan.sv
// Purpose : one PWM channel: shadow sample, period-aligned active value, optional
//           dead-time FSM on direction reversal, registered H-bridge leg outputs.
// Latency : legs lag i_cnt by 1 clock; new sample takes effect at the next i_wrap.
// Backpressure: none, every i_we is accepted.
// Optional feature macro: PID_PWM_DEADTIME_EN (builds the DEAD state and dead counter).
// Ports   : clk_pid/reset (async, active-high); i_we sample strobe for this channel;
//           i_m_k signed power word; i_cnt/i_wrap shared period counter and its wrap;
//           o_in_a forward leg, o_in_b reverse leg.
module pid_pwm_chan
  import pid_pwm_pkg::*;
#(
  parameter int ow = 12
`ifdef PID_PWM_DEADTIME_EN
  ,
  parameter int dt = 4
`endif
) (
  input  logic                 clk_pid,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic signed [ow-1:0] i_m_k,
  input  logic        [ow-2:0] i_cnt,
  input  logic                 i_wrap,
  output logic                 o_in_a,
  output logic                 o_in_b
);

  logic [ow-2:0] w_mag;
  logic          w_run;
  logic          w_on;

  logic          r_sh_sign;
  logic [ow-2:0] r_sh_mag;
  logic          r_act_sign;
  logic [ow-2:0] r_act_mag;
  logic          r_in_a;
  logic          r_in_b;

  assign w_mag = (ow-1)'(sat_abs(32'(i_m_k), ow));

  // Shadow registers follow every accepted sample.
  always_ff @(posedge clk_pid or posedge reset) begin
    if (reset) begin
      r_sh_sign <= 1'b0;
      r_sh_mag  <= '0;
    end else if (i_we) begin
      r_sh_sign <= i_m_k[ow-1];
      r_sh_mag  <= w_mag;
    end
  end

  // Active value only changes at the period boundary, so a period is never cut short
  // or stretched. A sample written on the wrap edge is not seen here until next wrap.
  always_ff @(posedge clk_pid or posedge reset) begin
    if (reset) begin
      r_act_sign <= 1'b0;
      r_act_mag  <= '0;
    end else if (i_wrap) begin
      r_act_sign <= r_sh_sign;
      r_act_mag  <= r_sh_mag;
    end
  end

`ifdef PID_PWM_DEADTIME_EN
  pwm_state_t r_state;
  logic [7:0] r_dead;
  logic       w_rev;

  // Reversal is judged against the value being loaded; loading zero never needs a gap.
  assign w_rev = (r_sh_sign != r_act_sign) && (r_sh_mag != '0);

  // Dead cycles start at cnt 0, so they eat into the start of the new on-time.
  always_ff @(posedge clk_pid or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_dead  <= '0;
    end else if (i_wrap && w_rev) begin
      r_state <= ST_DEAD;
      r_dead  <= 8'(dt);
    end else if (r_state == ST_DEAD) begin
      if (r_dead == 8'd1) begin
        r_state <= ST_RUN;
      end
      r_dead <= r_dead - 8'd1;
    end
  end

  assign w_run = (r_state == ST_RUN);
`else
  assign w_run = 1'b1;
`endif

  // cnt never reaches MAXC+1, so a magnitude of MAXC+1 drives the whole period.
  assign w_on = w_run && (i_cnt < r_act_mag);

  always_ff @(posedge clk_pid or posedge reset) begin
    if (reset) begin
      r_in_a <= 1'b0;
      r_in_b <= 1'b0;
    end else begin
      r_in_a <= w_on && !r_act_sign;
      r_in_b <= w_on && r_act_sign;
    end
  end

  assign o_in_a = r_in_a;
  assign o_in_b = r_in_b;

endmodule

// File: rtl/pid_pwm_out.sv
// Purpose : PWM output stage for the time-multiplexed PID core: per-channel shadow of
//           m_k, shared period counter, sign-magnitude H-bridge drive.
// Latency : outputs registered, 1 clock behind cnt; ce-to-drive 2 clocks .. period+2.
// Backpressure: none, every ce is accepted including back-to-back strobes.
// Optional feature macro: PID_PWM_DEADTIME_EN (dead time of dt clocks on reversal).
// Ports   : clk_pid, reset (async, active-high); ce/a/m_k sample strobe, channel
//           address and signed power; in_a/in_b per-channel legs; pwm_sync period pulse.
module pid_pwm_out
  import pid_pwm_pkg::*;
#(
  parameter int aw = 1,
  parameter int an = 1 << aw,
  parameter int ow = 12,
  parameter int dt = 4
) (
  input  logic                 clk_pid,
  input  logic                 reset,
  input  logic                 ce,
  input  logic        [aw-1:0] a,
  input  logic signed [ow-1:0] m_k,
  output logic        [an-1:0] in_a,
  output logic        [an-1:0] in_b,
  output logic                 pwm_sync
);

  localparam logic [ow-2:0] MAXC = (ow-1)'(pwm_maxc(ow));

  // Parameter sanity, evaluated at elaboration only.
  if (dt < 1 || dt > 255 || an > (1 << aw) || an < 1) begin : g_bad_param
    $error("pid_pwm_out: dt must be 1..255 and an must be 1..2^aw");
  end

  logic [ow-2:0] r_cnt;
  logic          r_sync;
  logic          w_wrap;
  logic [an-1:0] w_we;

  assign w_wrap = (r_cnt == MAXC);

  always_ff @(posedge clk_pid or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered like the legs, so the pulse lines up with the drive computed at cnt 0.
  always_ff @(posedge clk_pid or posedge reset) begin
    if (reset) begin
      r_sync <= 1'b0;
    end else begin
      r_sync <= (r_cnt == '0);
    end
  end

  assign pwm_sync = r_sync;

  for (genvar i = 0; i < an; i++) begin : g_chan
    assign w_we[i] = ce && (a == aw'(i));

    pid_pwm_chan #(
      .ow(ow)
`ifdef PID_PWM_DEADTIME_EN
      ,
      .dt(dt)
`endif
    ) u_chan (
      .clk_pid(clk_pid),
      .reset  (reset),
      .i_we   (w_we[i]),
      .i_m_k  (m_k),
      .i_cnt  (r_cnt),
      .i_wrap (w_wrap),
      .o_in_a (in_a[i]),
      .o_in_b (in_b[i])
    );
  end

endmodule

// File: tb/tb_pid_pwm_out.sv
// Purpose : self-checking bench for pid_pwm_out with default parameters.
// Latency : n/a. Backpressure: n/a.
module tb_pid_pwm_out;

  localparam int AW   = 1;
  localparam int AN   = 2;
  localparam int OW   = 12;
  localparam int DT   = 4;
  localparam int PER  = 2047;
  localparam int FULL = 2047;
`ifdef PID_PWM_DEADTIME_EN
  localparam int DTX = DT;
`else
  localparam int DTX = 0;
`endif

  logic                 clk_pid = 1'b0;
  logic                 reset   = 1'b0;
  logic                 ce      = 1'b0;
  logic        [AW-1:0] a       = '0;
  logic signed [OW-1:0] m_k     = '0;
  logic        [AN-1:0] in_a;
  logic        [AN-1:0] in_b;
  logic                 pwm_sync;

  always #5 clk_pid = ~clk_pid;

  pid_pwm_out #(.aw(AW), .an(AN), .ow(OW), .dt(DT)) dut (
    .clk_pid (clk_pid),
    .reset   (reset),
    .ce      (ce),
    .a       (a),
    .m_k     (m_k),
    .in_a    (in_a),
    .in_b    (in_b),
    .pwm_sync(pwm_sync)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a period phase 0..PER-1, shadow and active magnitudes as plain
  // integers, and a "reversed this period" flag that blanks the first DTX phases.
  int          m_ph;
  int          sh_mag[AN];
  int          sh_sgn[AN];
  int          ac_mag[AN];
  int          ac_sgn[AN];
  bit          rev[AN];
  logic [AN-1:0] ex_a;
  logic [AN-1:0] ex_b;
  logic        ex_sync;
  int          mv;
  bit          mon;

  always @(posedge clk_pid or posedge reset) begin
    if (reset) begin
      m_ph    = 0;
      ex_a    = '0;
      ex_b    = '0;
      ex_sync = 1'b0;
      for (int ch = 0; ch < AN; ch++) begin
        sh_mag[ch] = 0; sh_sgn[ch] = 0; ac_mag[ch] = 0; ac_sgn[ch] = 0; rev[ch] = 0;
      end
    end else begin
      ex_sync = (m_ph == 0);
      for (int ch = 0; ch < AN; ch++) begin
        mon = !(rev[ch] && m_ph < DTX) && (m_ph < ac_mag[ch]);
        ex_a[ch] = mon && (ac_sgn[ch] == 0);
        ex_b[ch] = mon && (ac_sgn[ch] == 1);
      end
      if (m_ph == PER - 1) begin
        m_ph = 0;
        for (int ch = 0; ch < AN; ch++) begin
          rev[ch]    = (sh_sgn[ch] != ac_sgn[ch]) && (sh_mag[ch] != 0);
          ac_mag[ch] = sh_mag[ch];
          ac_sgn[ch] = sh_sgn[ch];
        end
      end else begin
        m_ph = m_ph + 1;
      end
      if (ce) begin
        mv = int'(m_k);
        sh_sgn[a] = (mv < 0) ? 1 : 0;
        mv = (mv < 0) ? -mv : mv;
        sh_mag[a] = (mv > FULL) ? FULL : mv;
      end
    end
  end

  bit chk_en = 0;

  always @(negedge clk_pid) begin
    if (chk_en) begin
      checks++;
      if ({in_a, in_b, pwm_sync} !== {ex_a, ex_b, ex_sync}) begin
        errors++;
        $display("FAIL cycle_model t=%0t got a=%b b=%b sync=%b want a=%b b=%b sync=%b",
                 $time, in_a, in_b, pwm_sync, ex_a, ex_b, ex_sync);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, got, exp);
    end
  endtask

  task automatic wait_sync();
    for (int i = 0; i < PER + 10; i++) begin
      @(negedge clk_pid);
      if (pwm_sync === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL sync_timeout t=%0t got no pwm_sync want pulse", $time);
  endtask

  // Caller is on the negedge of a pwm_sync cycle; counts one full period of leg activity.
  task automatic count_period(output int na0, output int nb0, output int na1, output int nb1);
    na0 = 0; nb0 = 0; na1 = 0; nb1 = 0;
    for (int i = 0; i < PER; i++) begin
      if (i > 0) @(negedge clk_pid);
      na0 += int'(in_a[0]); nb0 += int'(in_b[0]);
      na1 += int'(in_a[1]); nb1 += int'(in_b[1]);
    end
  endtask

  // Caller is on a negedge; strobe is seen by exactly one posedge.
  task automatic send(input int ch, input int val);
    ce  = 1'b1;
    a   = AW'(ch);
    m_k = OW'(val);
    @(negedge clk_pid);
    ce  = 1'b0;
  endtask

  function automatic int rv(input int m);
    return (m > DTX) ? m - DTX : 0;
  endfunction

  typedef struct {
    int ch;
    int val;
    int e0a;
    int e0b;
    int e1a;
    int e1b;
  } vec_t;

  vec_t tv[8];

  initial begin
    #900000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int na0, nb0, na1, nb1, n;

    tv[0] = '{0,  1024, 1024, 0,       0,        0};
    tv[1] = '{1, -2048, 1024, 0,       0,        rv(2047)};
    tv[2] = '{0,   500,  500, 0,       0,        2047};
    tv[3] = '{0,  -500,    0, rv(500), 0,        2047};
    tv[4] = '{0,     0,    0, 0,       0,        2047};
    tv[5] = '{1,  2047,    0, 0,       rv(2047), 0};
    tv[6] = '{1,     1,    0, 0,       1,        0};
    tv[7] = '{0,    -1,    0, rv(1),   1,        0};

    // Reset held 5 clocks, outputs low throughout.
    #1 reset = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_pid);
      chk("reset_outputs", int'({in_a, in_b, pwm_sync}), 0);
    end
    reset = 1'b0;
    @(negedge clk_pid);
    chk("first_sync", int'(pwm_sync), 1);
    n = 0;
    for (int i = 0; i < PER + 10; i++) begin
      @(negedge clk_pid);
      n++;
      if (pwm_sync === 1'b1) break;
    end
    chk("sync_period", n, PER);

    // Table: sample mid-period, then measure the full period after the next wrap.
    for (int v = 0; v < 8; v++) begin
      wait_sync();
      repeat (500) @(negedge clk_pid);
      send(tv[v].ch, tv[v].val);
      wait_sync();
      count_period(na0, nb0, na1, nb1);
      chk($sformatf("vec%0d_in_a0", v), na0, tv[v].e0a);
      chk($sformatf("vec%0d_in_b0", v), nb0, tv[v].e0b);
      chk($sformatf("vec%0d_in_a1", v), na1, tv[v].e1a);
      chk($sformatf("vec%0d_in_b1", v), nb1, tv[v].e1b);
    end

    // Sample coincident with wrap: old shadow loads now, new one a period later.
    wait_sync();
    repeat (500) @(negedge clk_pid);
    send(0, 300);
    wait_sync();
    repeat (PER - 2) @(negedge clk_pid);
    send(0, 700);
    wait_sync();
    count_period(na0, nb0, na1, nb1);
    chk("same_edge_old_a0", na0, 300);
    wait_sync();
    count_period(na0, nb0, na1, nb1);
    chk("same_edge_new_a0", na0, 700);

    // Random samples at random phases, including back-to-back strobes.
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(1, 600)) @(negedge clk_pid);
      send(int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)) - 2048);
      if (k % 4 == 0) send(int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)) - 2048);
    end
    repeat (2 * PER) @(negedge clk_pid);

    // Reset mid-period while channel 0 is driving forward.
    send(0, 700);
    wait_sync();
    wait_sync();
    repeat (300) @(negedge clk_pid);
    chk("pre_reset_in_a0", int'(in_a[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_in_a0", int'(in_a[0]), 0);
    chk("async_reset_sync", int'(pwm_sync), 0);
    repeat (3) @(negedge clk_pid);
    reset = 1'b0;
    wait_sync();
    count_period(na0, nb0, na1, nb1);
    chk("post_reset_legs", na0 + nb0 + na1 + nb1, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
